traffic_light_controller: RTL
=============================

# traffic_light_controller

Sequences the lights of a two-road junction: a main road that rests on green and a side road served on demand. The side-road vehicle-present signal from the traffic sensor LFSR block drives the demand. The controller latches that demand and enforces minimum main green, minimum and maximum side green, yellow and all-red clearance intervals. A cycle counter times every phase.

## Interface
Parameters:
- CNT_W, 8: phase counter width; every duration parameter must be ≤ 2^CNT_W.
- MAIN_MIN, 8: minimum main-green duration, cycles (≥1).
- SIDE_MIN, 4: minimum side-green duration, cycles (≥1).
- SIDE_MAX, 10: maximum side-green duration, cycles (≥ SIDE_MIN).
- YEL, 3: yellow duration, cycles (≥1).
- AR, 2: all-red duration, cycles (≥1).

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- side_req  in  1  side-road vehicle present (sensor output T); synchronous to clk.
- main_light  out  3  {R,Y,G} one-hot for the main road.
- side_light  out  3  {R,Y,G} one-hot for the side road.
- state  out  3  current phase code, for debug and monitoring.

## Operation
- Phases and state codes:
  - MAIN_GREEN=0: main G, side R.
  - MAIN_YELLOW=1: main Y, side R.
  - ALL_RED_1=2: both R.
  - SIDE_GREEN=3: main R, side G.
  - SIDE_YELLOW=4: main R, side Y.
  - ALL_RED_2=5: both R.
  - Codes 6 and 7 are illegal; they go to MAIN_GREEN on the next edge.
- Lights are a pure decode of the state register; they are never both green and never both non-red.
- cnt: up-counter, cleared to 0 on the edge that enters any phase, incremented every cycle in the phase.
  - It saturates at 2^CNT_W−1 and never wraps.
- req_lat (sticky demand):
  - Set on any edge where side_req=1 and the current state is not SIDE_GREEN.
  - Cleared on the edge entering SIDE_GREEN, which takes priority over set.
- Transitions, evaluated every edge:
  - MAIN_GREEN → MAIN_YELLOW when cnt ≥ MAIN_MIN−1 and (req_lat or side_req).
  - MAIN_YELLOW → ALL_RED_1 when cnt = YEL−1.
  - ALL_RED_1 → SIDE_GREEN when cnt = AR−1.
  - SIDE_GREEN → SIDE_YELLOW when cnt = SIDE_MAX−1, or when cnt ≥ SIDE_MIN−1 and side_req=0. The maximum always wins over a continued request.
  - SIDE_YELLOW → ALL_RED_2 when cnt = YEL−1.
  - ALL_RED_2 → MAIN_GREEN when cnt = AR−1.
- Demand arriving during SIDE_YELLOW or ALL_RED_2 is latched. It forces another side phase once the next main green has run its minimum.
- No demand: the controller rests in MAIN_GREEN indefinitely with cnt saturated.

## Timing
- Reset (asynchronous, takes effect immediately):
  - state=MAIN_GREEN, cnt=0, req_lat=0.
  - main_light=3'b001, side_light=3'b100, state=3'd0.
- Release: the first rising edge after rst falls counts cycle 0 of MAIN_GREEN.
- Without extension, each phase lasts exactly its parameter value in cycles. Side green lasts between SIDE_MIN and SIDE_MAX cycles.
- Demand latency: a side_req seen at or after main cycle MAIN_MIN−1 moves to MAIN_YELLOW on the next edge. Side green follows YEL+AR cycles later.
- Reset mid-phase aborts at once to MAIN_GREEN with no yellow or all-red, and drops any latched demand.
- Simultaneous events:
  - side_req=1 on the edge entering SIDE_GREEN: the latch stays clear.
  - side_req=1 with cnt = MAIN_MIN−1 in MAIN_GREEN: the transition is taken with no latch delay.

## Test plan
Defaults apply; t = cycles after reset release.
- Idle: no side_req for 300 cycles → main_light=001 and side_light=100 throughout; cnt saturates at 255 without wrap.
- Single pulse: side_req=1 at t=2 only →
  - MAIN_GREEN t0–7, MAIN_YELLOW t8–10, ALL_RED_1 t11–12.
  - SIDE_GREEN t13–16, SIDE_YELLOW t17–19, ALL_RED_2 t20–21, MAIN_GREEN from t22.
- Held demand: side_req=1 continuously → SIDE_GREEN lasts exactly 10 cycles (t13–22). Main then gets exactly 8 cycles before the next MAIN_YELLOW.
- Late request: side_req pulse at t=20 → MAIN_YELLOW at t21, SIDE_GREEN at t26.
- Queued demand: side_req pulse during SIDE_YELLOW → req_lat=1, main green lasts exactly 8 cycles, a second side phase follows.
- Async reset asserted mid SIDE_GREEN, between edges → lights read main 001 / side 100 before the next edge. After release the sequence restarts as in the idle case, with no residual demand.

Source files
------------

// File: rtl/traffic_light_controller.sv
// Two-road junction sequencer: main road rests on green, side road is served on
// latched demand with min/max green, yellow and all-red clearance timing.
module traffic_light_controller #(
  parameter int CNT_W    = 8,
  parameter int MAIN_MIN = 8,
  parameter int SIDE_MIN = 4,
  parameter int SIDE_MAX = 10,
  parameter int YEL      = 3,
  parameter int AR       = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       side_req,
  output logic [2:0] main_light,
  output logic [2:0] side_light,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    MAIN_GREEN  = 3'd0,
    MAIN_YELLOW = 3'd1,
    ALL_RED_1   = 3'd2,
    SIDE_GREEN  = 3'd3,
    SIDE_YELLOW = 3'd4,
    ALL_RED_2   = 3'd5
  } phase_e;

  localparam logic [2:0] L_RED = 3'b100;
  localparam logic [2:0] L_YEL = 3'b010;
  localparam logic [2:0] L_GRN = 3'b001;

  localparam logic [CNT_W-1:0] MAIN_LAST = CNT_W'(MAIN_MIN - 1);
  localparam logic [CNT_W-1:0] SMIN_LAST = CNT_W'(SIDE_MIN - 1);
  localparam logic [CNT_W-1:0] SMAX_LAST = CNT_W'(SIDE_MAX - 1);
  localparam logic [CNT_W-1:0] YEL_LAST  = CNT_W'(YEL - 1);
  localparam logic [CNT_W-1:0] AR_LAST   = CNT_W'(AR - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  phase_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             req_lat_q, req_lat_d;
  logic             demand;

  assign demand = req_lat_q | side_req;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= MAIN_GREEN;
      cnt_q     <= '0;
      req_lat_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      req_lat_q <= req_lat_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      MAIN_GREEN:  if (cnt_q >= MAIN_LAST && demand) state_d = MAIN_YELLOW;
      MAIN_YELLOW: if (cnt_q == YEL_LAST)            state_d = ALL_RED_1;
      ALL_RED_1:   if (cnt_q == AR_LAST)             state_d = SIDE_GREEN;
      // The max-green limit ends the phase even while the side road still asks.
      SIDE_GREEN:  if (cnt_q == SMAX_LAST || (cnt_q >= SMIN_LAST && !side_req))
                     state_d = SIDE_YELLOW;
      SIDE_YELLOW: if (cnt_q == YEL_LAST)            state_d = ALL_RED_2;
      ALL_RED_2:   if (cnt_q == AR_LAST)             state_d = MAIN_GREEN;
      default:     state_d = MAIN_GREEN;
    endcase
  end

  // Counter restarts on every phase entry and saturates while main rests.
  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q)  cnt_d = '0;
    else if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
  end

  // Entering side green consumes the demand, even if side_req is high that edge.
  always_comb begin
    req_lat_d = req_lat_q;
    if (state_d == SIDE_GREEN && state_q != SIDE_GREEN) req_lat_d = 1'b0;
    else if (side_req && state_q != SIDE_GREEN)         req_lat_d = 1'b1;
  end

  always_comb begin
    main_light = L_RED;
    side_light = L_RED;
    case (state_q)
      MAIN_GREEN:  main_light = L_GRN;
      MAIN_YELLOW: main_light = L_YEL;
      SIDE_GREEN:  side_light = L_GRN;
      SIDE_YELLOW: side_light = L_YEL;
      default: ;
    endcase
  end

  assign state = state_q;

endmodule
